multicycle_control: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath; sits directly upstream of the ALU control decoder and drives its 2-bit ALUOp input.
- Sequences each instruction through fetch, decode, execute, memory and write-back states from the 6-bit opcode held in the instruction register.
- Asserts every datapath enable and mux select.
- Stalls on a ready/valid-style memory handshake.

---
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and write-back,
// decodes every datapath enable and mux select from the current state, and
// stalls the memory states on the mem_ready handshake.
module multicycle_control #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] branch_type,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_size,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] R_EXEC    = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] JUMP      = 4'd9;
  localparam logic [3:0] I_EXEC    = 4'd10;
  localparam logic [3:0] I_WB      = 4'd11;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_ready;
  logic [3:0] w_decode_next;
  logic       w_legal;
  logic [1:0] w_mem_size;
  logic [1:0] w_branch_type;

  // Without the handshake the memory is assumed to answer in a single cycle.
  assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Opcode decode: DECODE successor, access width and branch flavour.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    w_decode_next = FETCH;
    w_legal       = 1'b1;
    w_mem_size    = 2'b00;
    w_branch_type = 2'b00;
    case (opcode)
      6'b000000:                       w_decode_next = R_EXEC;
      6'b100011, 6'b101011:            w_decode_next = MEM_ADDR;
      6'b100001, 6'b101001: begin      w_decode_next = MEM_ADDR; w_mem_size = 2'b01; end
      6'b100000, 6'b101000: begin      w_decode_next = MEM_ADDR; w_mem_size = 2'b10; end
      6'b000100: begin                 w_decode_next = BRANCH;   w_branch_type = 2'b01; end
      6'b000101: begin                 w_decode_next = BRANCH;   w_branch_type = 2'b10; end
      6'b000001: begin                 w_decode_next = BRANCH;   w_branch_type = 2'b11; end
      6'b000010:                       w_decode_next = JUMP;
      6'b001000, 6'b111111, 6'b001100,
      6'b001101, 6'b001010, 6'b001111: w_decode_next = I_EXEC;
      default:                         w_legal = 1'b0;
    endcase
  end

  // Next-state selection; memory states hold until the access completes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:     w_next = w_ready ? DECODE : FETCH;
      DECODE:    w_next = w_decode_next;
      MEM_ADDR:  w_next = opcode[3] ? MEM_WRITE : MEM_READ;
      MEM_READ:  w_next = w_ready ? MEM_WB : MEM_READ;
      MEM_WB:    w_next = FETCH;
      MEM_WRITE: w_next = w_ready ? FETCH : MEM_WRITE;
      R_EXEC:    w_next = R_WB;
      R_WB:      w_next = FETCH;
      BRANCH:    w_next = FETCH;
      JUMP:      w_next = FETCH;
      I_EXEC:    w_next = I_WB;
      I_WB:      w_next = FETCH;
      default:   w_next = FETCH;
    endcase
  end

  // State register with synchronous reset that overrides any stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  // Moore output decode; only the FETCH load strobes look at mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_type   = 2'b00;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_size      = 2'b00;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;
    case (r_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = w_ready;
        pc_write  = w_ready;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~w_legal;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        mem_size  = w_mem_size;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        mem_size = w_mem_size;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        mem_size   = w_mem_size;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        mem_size  = w_mem_size;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_type   = w_branch_type;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      I_WB: begin
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a vector table, hand-built
// corner sequences (reset mid-store, stalls, illegal opcode) and randomized
// instruction streams compared against an instruction-level reference model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, reg_write, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] branch_type, pc_source, mem_size, alu_src_b, alu_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_type(branch_type),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcwc;
    logic [1:0] bt;
    logic [1:0] psrc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic [1:0] msz;
    logic       irw;
    logic       rdst;
    logic       rwr;
    logic       m2r;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       ill;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  // Opcode lists of the supported instruction set.
  function automatic bit is_load(input logic [5:0] op);
    return op inside {6'b100011, 6'b100001, 6'b100000};
  endfunction
  function automatic bit is_store(input logic [5:0] op);
    return op inside {6'b101011, 6'b101001, 6'b101000};
  endfunction
  function automatic bit is_branch(input logic [5:0] op);
    return op inside {6'b000100, 6'b000101, 6'b000001};
  endfunction
  function automatic bit is_imm(input logic [5:0] op);
    return op inside {6'b001000, 6'b111111, 6'b001100, 6'b001101, 6'b001010, 6'b001111};
  endfunction
  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b000010 || is_load(op) || is_store(op) ||
           is_branch(op) || is_imm(op);
  endfunction
  function automatic logic [1:0] size_of(input logic [5:0] op);
    if (op == 6'b100011 || op == 6'b101011) return 2'b00;
    if (op == 6'b100001 || op == 6'b101001) return 2'b01;
    return 2'b10;
  endfunction
  function automatic logic [1:0] btype_of(input logic [5:0] op);
    if (op == 6'b000100) return 2'b01;
    if (op == 6'b000101) return 2'b10;
    return 2'b11;
  endfunction

  // Expected control word for one cycle of a given phase of the instruction.
  function automatic outs_t model(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    outs_t o;
    o = '0;
    o.st = st;
    case (st)
      4'd0:  begin o.mrd = 1'b1; o.asb = 2'b01; o.irw = rdy; o.pcw = rdy; end
      4'd1:  begin o.asb = 2'b11; o.ill = !is_legal(op); end
      4'd2:  begin o.asa = 1'b1; o.asb = 2'b10; o.msz = size_of(op); end
      4'd3:  begin o.mrd = 1'b1; o.iord = 1'b1; o.msz = size_of(op); end
      4'd4:  begin o.rwr = 1'b1; o.m2r = 1'b1; o.msz = size_of(op); end
      4'd5:  begin o.mwr = 1'b1; o.iord = 1'b1; o.msz = size_of(op); end
      4'd6:  begin o.asa = 1'b1; o.aop = 2'b10; end
      4'd7:  begin o.rwr = 1'b1; o.rdst = 1'b1; end
      4'd8:  begin o.asa = 1'b1; o.aop = 2'b01; o.pcwc = 1'b1; o.psrc = 2'b01; o.bt = btype_of(op); end
      4'd9:  begin o.pcw = 1'b1; o.psrc = 2'b10; end
      4'd10: begin o.asa = 1'b1; o.asb = 2'b10; o.aop = 2'b11; end
      4'd11: begin o.rwr = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.st = state;  o.pcw = pc_write; o.pcwc = pc_write_cond; o.bt = branch_type;
    o.psrc = pc_source; o.iord = iord; o.mrd = mem_read; o.mwr = mem_write;
    o.msz = mem_size; o.irw = ir_write; o.rdst = reg_dst; o.rwr = reg_write;
    o.m2r = mem_to_reg; o.asa = alu_src_a; o.asb = alu_src_b; o.aop = alu_op;
    o.ill = illegal_op;
    return o;
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare shortly after.
  task automatic cyc(input logic [5:0] op, input logic rdy, input outs_t exp, input string name);
    @(negedge clk);
    opcode    = op;
    mem_ready = rdy;
    #1;
    check(name, sample(), exp);
  endtask

  // Runs one instruction from FETCH with the given stall counts.
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input string name);
    step_t q[$];
    for (int i = 0; i < fstall; i++) q.push_back('{4'd0, 1'b0});
    q.push_back('{4'd0, 1'b1});
    q.push_back('{4'd1, 1'($urandom_range(0, 1))});
    if (op == 6'b000000) begin
      q.push_back('{4'd6, 1'($urandom_range(0, 1))});
      q.push_back('{4'd7, 1'($urandom_range(0, 1))});
    end else if (is_imm(op)) begin
      q.push_back('{4'd10, 1'($urandom_range(0, 1))});
      q.push_back('{4'd11, 1'($urandom_range(0, 1))});
    end else if (is_load(op) || is_store(op)) begin
      q.push_back('{4'd2, 1'($urandom_range(0, 1))});
      for (int i = 0; i < mstall; i++) q.push_back('{is_load(op) ? 4'd3 : 4'd5, 1'b0});
      q.push_back('{is_load(op) ? 4'd3 : 4'd5, 1'b1});
      if (is_load(op)) q.push_back('{4'd4, 1'($urandom_range(0, 1))});
    end else if (is_branch(op)) begin
      q.push_back('{4'd8, 1'($urandom_range(0, 1))});
    end else if (op == 6'b000010) begin
      q.push_back('{4'd9, 1'($urandom_range(0, 1))});
    end
    foreach (q[i]) begin
      logic [5:0] drv;
      // The IR still holds the previous instruction while fetching.
      drv = (q[i].st == 4'd0) ? 6'($urandom) : op;
      cyc(drv, q[i].rdy, model(q[i].st, op, q[i].rdy), name);
    end
  endtask

  vec_t tbl[10];
  logic [5:0] legal_ops[18];

  initial begin
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b100000, 6'b101000, 6'b100001,
                  6'b101001, 6'b000100, 6'b000101, 6'b000001, 6'b000010, 6'b001000,
                  6'b111111, 6'b001100, 6'b001101, 6'b001010, 6'b001111, 6'b011100};

    tbl[0] = '{6'b000000, 1'b1, outs_t'{st:4'd0, pcw:1'b1, irw:1'b1, mrd:1'b1, asb:2'b01, default:'0}};
    tbl[1] = '{6'b000000, 1'b1, outs_t'{st:4'd1, asb:2'b11, default:'0}};
    tbl[2] = '{6'b000000, 1'b1, outs_t'{st:4'd6, asa:1'b1, aop:2'b10, default:'0}};
    tbl[3] = '{6'b000000, 1'b1, outs_t'{st:4'd7, rwr:1'b1, rdst:1'b1, default:'0}};
    tbl[4] = '{6'b000101, 1'b1, outs_t'{st:4'd0, pcw:1'b1, irw:1'b1, mrd:1'b1, asb:2'b01, default:'0}};
    tbl[5] = '{6'b000101, 1'b1, outs_t'{st:4'd1, asb:2'b11, default:'0}};
    tbl[6] = '{6'b000101, 1'b1, outs_t'{st:4'd8, asa:1'b1, aop:2'b01, pcwc:1'b1, psrc:2'b01,
                                        bt:2'b10, default:'0}};
    tbl[7] = '{6'b000010, 1'b0, outs_t'{st:4'd0, mrd:1'b1, asb:2'b01, default:'0}};
    tbl[8] = '{6'b000010, 1'b1, outs_t'{st:4'd0, pcw:1'b1, irw:1'b1, mrd:1'b1, asb:2'b01, default:'0}};
    tbl[9] = '{6'b000010, 1'b1, outs_t'{st:4'd1, asb:2'b11, default:'0}};

    rst_n     = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", sample(), outs_t'{st:4'd0, mrd:1'b1, asb:2'b01, default:'0});
    rst_n = 1'b1;

    // Table vectors: R-type, bne, and jump's fetch/decode (jump body below).
    foreach (tbl[i]) cyc(tbl[i].op, tbl[i].rdy, tbl[i].exp, $sformatf("table_%0d", i));
    cyc(6'b000010, 1'b0, outs_t'{st:4'd9, pcw:1'b1, psrc:2'b10, default:'0}, "jump_exec");

    // Reset held two cycles during a stalled store kills the write.
    cyc(6'b101011, 1'b1, outs_t'{st:4'd0, pcw:1'b1, irw:1'b1, mrd:1'b1, asb:2'b01, default:'0}, "rst_sw_fetch");
    cyc(6'b101011, 1'b0, outs_t'{st:4'd1, asb:2'b11, default:'0}, "rst_sw_decode");
    cyc(6'b101011, 1'b0, outs_t'{st:4'd2, asa:1'b1, asb:2'b10, default:'0}, "rst_sw_addr");
    cyc(6'b101011, 1'b0, outs_t'{st:4'd5, mwr:1'b1, iord:1'b1, default:'0}, "rst_sw_stall");
    rst_n = 1'b0;
    cyc(6'b101011, 1'b0, outs_t'{st:4'd0, mrd:1'b1, asb:2'b01, default:'0}, "rst_mid_store_1");
    cyc(6'b101011, 1'b0, outs_t'{st:4'd0, mrd:1'b1, asb:2'b01, default:'0}, "rst_mid_store_2");
    rst_n = 1'b1;
    cyc(6'b101011, 1'b0, outs_t'{st:4'd0, mrd:1'b1, asb:2'b01, default:'0}, "post_rst_fetch_stall");

    // lw with three stalled MEM_READ cycles.
    run_instr(6'b100011, 0, 3, "lw_stall");
    // sh then lb.
    run_instr(6'b101001, 0, 0, "sh");
    run_instr(6'b100000, 0, 0, "lb");
    // bgez and jump via the model.
    run_instr(6'b000001, 0, 0, "bgez");
    run_instr(6'b000010, 0, 0, "jump");
    // Illegal opcode, then a fetch stalled two cycles.
    run_instr(6'b011100, 0, 0, "illegal");
    run_instr(6'b001101, 2, 0, "fetch_stall");
    // Store with a long stall holds mem_write throughout.
    run_instr(6'b101000, 4, 5, "sb_stall");

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 17)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 4), $sformatf("rand_%0d_op%b", n, op));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
